// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } hazard_state_t;

  localparam int unsigned ZERO_REG_IDX = 32'd0;

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Combinational load-use hazard detector: the load in EX feeds a source read in ID.
module load_use_detect
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  idex_mem_read_i,
  input  logic [REG_ADDR_W-1:0] idex_rd_i,
  input  logic [REG_ADDR_W-1:0] ifid_rs1_i,
  input  logic [REG_ADDR_W-1:0] ifid_rs2_i,
  input  logic                  ifid_uses_rs1_i,
  input  logic                  ifid_uses_rs2_i,
  output logic                  load_use_o
);

  logic rs1_hit_s;
  logic rs2_hit_s;
  logic rd_live_s;

  assign rs1_hit_s  = ifid_uses_rs1_i & (ifid_rs1_i == idex_rd_i);
  assign rs2_hit_s  = ifid_uses_rs2_i & (ifid_rs2_i == idex_rd_i);
  // Writes to the zero register never produce a value worth waiting for.
  assign rd_live_s  = (idex_rd_i != REG_ADDR_W'(ZERO_REG_IDX));
  assign load_use_o = idex_mem_read_i & rd_live_s & (rs1_hit_s | rs2_hit_s);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline; owns one deferred redirect (DRAIN).
// Optional PIPE_HAZARD_PERF_EN adds stall/bubble/redirect performance counters.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  imem_stall,
  input  logic                  dmem_stall,
  input  logic                  ex_redirect,
  input  logic [XLEN-1:0]       ex_target,
  input  logic                  idex_mem_read,
  input  logic [REG_ADDR_W-1:0] idex_rd,
  input  logic [REG_ADDR_W-1:0] ifid_rs1,
  input  logic [REG_ADDR_W-1:0] ifid_rs2,
  input  logic                  ifid_uses_rs1,
  input  logic                  ifid_uses_rs2,
  output logic                  pc_en,
  output logic                  pc_redirect,
  output logic [XLEN-1:0]       pc_redirect_target,
  output logic                  ifid_en,
  output logic                  idex_en,
  output logic                  exmem_en,
  output logic                  memwb_en,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  drain_busy
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           bubble_cnt,
  output logic [31:0]           redirect_cnt
`endif
);

  hazard_state_t   state_q, state_d;
  logic [XLEN-1:0] saved_target_q, saved_target_d;
  logic            load_use_s;

  load_use_detect #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_load_use_detect (
    .idex_mem_read_i (idex_mem_read),
    .idex_rd_i       (idex_rd),
    .ifid_rs1_i      (ifid_rs1),
    .ifid_rs2_i      (ifid_rs2),
    .ifid_uses_rs1_i (ifid_uses_rs1),
    .ifid_uses_rs2_i (ifid_uses_rs2),
    .load_use_o      (load_use_s)
  );

  // Output decode and next-state selection from the current state and hazards.
  always_comb begin
    state_d            = state_q;
    saved_target_d     = saved_target_q;
    pc_en              = 1'b0;
    pc_redirect        = 1'b0;
    pc_redirect_target = {XLEN{1'b0}};
    ifid_en            = 1'b0;
    idex_en            = 1'b0;
    exmem_en           = 1'b0;
    memwb_en           = 1'b0;
    ifid_flush         = 1'b0;
    idex_flush         = 1'b0;
    drain_busy         = 1'b0;
    if (!rst) begin
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          pc_redirect_target = ex_target;
          if (dmem_stall) begin
            // Whole pipe freezes; EX re-presents any redirect once MEM completes.
            pc_en = 1'b0;
          end else if (ex_redirect) begin
            ifid_en    = 1'b1;
            idex_en    = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            if (imem_stall) begin
              saved_target_d = ex_target;
              state_d        = DRAIN;
            end else begin
              pc_en       = 1'b1;
              pc_redirect = 1'b1;
            end
          end else if (load_use_s) begin
            idex_en    = 1'b1;
            idex_flush = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
          end else if (imem_stall) begin
            ifid_en    = 1'b1;
            ifid_flush = 1'b1;
            idex_en    = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
          end else begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
          end
        end
        DRAIN: begin
          drain_busy         = 1'b1;
          ifid_en            = 1'b1;
          ifid_flush         = 1'b1;
          pc_redirect_target = saved_target_q;
          idex_en            = ~dmem_stall;
          exmem_en           = ~dmem_stall;
          memwb_en           = ~dmem_stall;
          idex_flush         = ~dmem_stall;
          // The wrong-path response lands now and is squashed by the IF/ID flush.
          if (imem_stall) begin
            pc_en = 1'b0;
          end else begin
            pc_en       = 1'b1;
            pc_redirect = 1'b1;
            state_d     = RUN;
          end
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  // FSM state and deferred redirect target.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= RUN;
      saved_target_q <= {XLEN{1'b0}};
    end else begin
      state_q        <= state_d;
      saved_target_q <= saved_target_d;
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] stall_cycles_q, bubble_cnt_q, redirect_cnt_q;

  // Free-running wrap-around performance counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles_q <= 32'd0;
      bubble_cnt_q   <= 32'd0;
      redirect_cnt_q <= 32'd0;
    end else begin
      stall_cycles_q <= stall_cycles_q + {31'd0, dmem_stall};
      bubble_cnt_q   <= bubble_cnt_q + {31'd0, idex_en & idex_flush};
      redirect_cnt_q <= redirect_cnt_q + {31'd0, pc_redirect};
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign bubble_cnt   = bubble_cnt_q;
  assign redirect_cnt = redirect_cnt_q;
`endif

endmodule
